// File: rtl/acc_mem_accumulator_mc.sv
// Multi-channel coherent pulse integrator with a per-channel accumulation memory.
// One trig starts a sweep of 2^DEPTH samples; the final sweep streams its sums out.
module acc_mem_accumulator_mc #(
    parameter int CHANNELS = 2,
    parameter int DIN_W    = 16,
    parameter int ACC_W    = 32,
    parameter int DEPTH    = 10,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trig,
    input  logic                      trig_int,
    input  logic                      trig_last,
    input  logic [CHANNELS*DIN_W-1:0] din,
    output logic [CHANNELS*ACC_W-1:0] dout,
    output logic                      dout_valid,
    output logic                      dout_last,
    output logic [CNT_W-1:0]          npulses,
    output logic                      busy,
    output logic                      overrun
);

    localparam int N = 2 ** DEPTH;
    localparam int MW = CHANNELS * ACC_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]               state;
    logic [DEPTH:0]           cnt;
    logic                     mode_int;
    logic                     mode_last;
    logic                     primed;
    logic                     issue;
    logic                     wr_en;
    logic [DEPTH-1:0]         wr_addr;
    logic [CHANNELS*DIN_W-1:0] din_q;
    logic [MW-1:0]            rd_data;
    logic [MW-1:0]            sum;
    logic [MW-1:0]            mem [N];
    logic                     first;

    // cnt runs 0..N: reads issue while cnt < N, cnt == N is the drain cycle
    assign issue = (state == S_RUN) && !cnt[DEPTH];
    assign busy  = (state == S_RUN);
    assign first = trig_int || !primed;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= sum;
        end
        if (issue) begin
            rd_data <= mem[cnt[DEPTH-1:0]];
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [ACC_W-1:0] ext;
        logic signed [ACC_W-1:0] old;
        logic signed [ACC_W-1:0] res;
        logic signed [ACC_W:0]   wide;

        always_comb begin
            ext  = ACC_W'($signed(din_q[c*DIN_W +: DIN_W]));
            old  = mode_int ? '0 : $signed(rd_data[c*ACC_W +: ACC_W]);
            wide = {old[ACC_W-1], old} + {ext[ACC_W-1], ext};
            res  = wide[ACC_W-1:0];
            if (SATURATE != 0 && (wide[ACC_W] != wide[ACC_W-1])) begin
                res = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end

        assign sum[c*ACC_W +: ACC_W] = res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mode_int   <= 1'b0;
            mode_last  <= 1'b0;
            primed     <= 1'b0;
            npulses    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            din_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= trig && (state == S_RUN);
            wr_en      <= issue;
            wr_addr    <= cnt[DEPTH-1:0];
            din_q      <= din;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;

            if (wr_en && mode_last) begin
                dout       <= sum;
                dout_valid <= 1'b1;
                dout_last  <= &wr_addr;
            end

            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        mode_int  <= first;
                        mode_last <= trig_last;
                        primed    <= 1'b1;
                        if (first) begin
                            npulses <= CNT_W'(1);
                        end else if (npulses != '1) begin
                            npulses <= npulses + CNT_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cnt[DEPTH]) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + (DEPTH+1)'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mem_accumulator_mc.sv
// Directed bench for acc_mem_accumulator_mc: pass-through, integration,
// saturation/wrap, overrun, reset mid-sweep and minimum-spacing sweeps.
module tb_acc_mem_accumulator_mc;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic        trig_int;
    logic        trig_last;
    logic [31:0] din;

    logic [63:0] dout_m;
    logic        valid_m, last_m, busy_m, ovr_m;
    logic [15:0] np_m;
    logic [35:0] dout_s;
    logic        valid_s, last_s, busy_s, ovr_s;
    logic [15:0] np_s;
    logic [35:0] dout_w;
    logic        valid_w, last_w, busy_w, ovr_w;
    logic [15:0] np_w;

    int     errors = 0;
    int     checks = 0;
    longint e0 [N];
    longint e1 [N];
    longint es;
    longint ew;
    bit     sw = 1'b0;

    always #5 clk = ~clk;

    acc_mem_accumulator_mc #(
        .CHANNELS(2), .DIN_W(16), .ACC_W(32),
        .DEPTH(4), .SATURATE(0), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .trig(trig),
        .trig_int(trig_int), .trig_last(trig_last), .din(din),
        .dout(dout_m), .dout_valid(valid_m), .dout_last(last_m),
        .npulses(np_m), .busy(busy_m), .overrun(ovr_m)
    );

    acc_mem_accumulator_mc #(
        .CHANNELS(2), .DIN_W(16), .ACC_W(18),
        .DEPTH(4), .SATURATE(1), .CNT_W(16)
    ) u_sat (
        .clk(clk), .rst(rst), .trig(trig),
        .trig_int(trig_int), .trig_last(trig_last), .din(din),
        .dout(dout_s), .dout_valid(valid_s), .dout_last(last_s),
        .npulses(np_s), .busy(busy_s), .overrun(ovr_s)
    );

    acc_mem_accumulator_mc #(
        .CHANNELS(2), .DIN_W(16), .ACC_W(18),
        .DEPTH(4), .SATURATE(0), .CNT_W(16)
    ) u_wrap (
        .clk(clk), .rst(rst), .trig(trig),
        .trig_int(trig_int), .trig_last(trig_last), .din(din),
        .dout(dout_w), .dout_valid(valid_w), .dout_last(last_w),
        .npulses(np_w), .busy(busy_w), .overrun(ovr_w)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] din_of(input int pat, input int k);
        int c0;
        int c1;
        case (pat)
            0:       begin c0 = -1024 + k; c1 = 7;  end
            1:       begin c0 = 100;       c1 = -k; end
            2:       begin c0 = 32767;     c1 = 32767; end
            default: begin c0 = 1;         c1 = 1;  end
        endcase
        return {16'(c1), 16'(c0)};
    endfunction

    // Called at a negedge: drives trig for cycle t0, then walks t0+1..t0+N+2
    task automatic sweep(input bit ti, input bit tl, input int pat,
                         input bit ov, input bit rs);
        trig      = 1'b1;
        trig_int  = ti;
        trig_last = tl;
        for (int j = 0; j <= N + 1; j++) begin
            bit live;
            bit vexp;
            @(negedge clk);
            trig      = 1'b0;
            trig_int  = 1'b0;
            trig_last = 1'b0;
            din  = (j < N) ? din_of(pat, j) : 32'h0;
            live = !(rs && j >= 8);
            vexp = tl && live && (j >= 2);
            check("valid", valid_m, vexp);
            if (vexp) begin
                check("dout_ch0", $signed(dout_m[31:0]), e0[j-2]);
                check("dout_ch1", $signed(dout_m[63:32]), e1[j-2]);
                check("last", last_m, (j - 2) == N - 1);
                if (sw) begin
                    check("sat_ch0", $signed(dout_s[17:0]), es);
                    check("sat_ch1", $signed(dout_s[35:18]), es);
                    check("wrap_ch0", $signed(dout_w[17:0]), ew);
                    check("wrap_ch1", $signed(dout_w[35:18]), ew);
                end
            end
            if (j == 0) check("busy_on", busy_m, 1);
            if (j == N) check("busy_end", busy_m, live);
            if (j == N + 1) check("busy_off", busy_m, 0);
            if (ov && j == 4) check("ovr_quiet", ovr_m, 0);
            if (ov && (j == 5 || j == N + 1)) check("overrun", ovr_m, 1);
            if (ov && j == 6) check("ovr_pulse", ovr_m, 0);
            if (rs && j == 8) begin
                check("rst_dout", dout_m, 0);
                check("rst_npulses", np_m, 0);
                check("rst_busy", busy_m, 0);
                check("rst_last", last_m, 0);
                check("rst_ovr", ovr_m, 0);
            end
            if (ov && (j == 4 || j == N)) begin
                trig      = 1'b1;
                trig_int  = 1'b0;
                trig_last = 1'b1;
            end
            rst = rs && (j == 7);
        end
    endtask

    initial begin
        rst = 1'b1;
        trig = 1'b0;
        trig_int = 1'b0;
        trig_last = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout_m, 0);
        check("reset_valid", valid_m, 0);
        check("reset_last", last_m, 0);
        check("reset_npulses", np_m, 0);
        check("reset_busy", busy_m, 0);
        check("reset_ovr", ovr_m, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < N; k++) begin
            e0[k] = -1024 + k;
            e1[k] = 7;
        end
        sweep(1, 1, 0, 0, 0);
        check("pt_npulses", np_m, 1);

        for (int k = 0; k < N; k++) begin
            e0[k] = 300;
            e1[k] = -3 * k;
        end
        sweep(1, 0, 1, 0, 0);
        sweep(0, 0, 1, 0, 0);
        sweep(0, 1, 1, 0, 0);
        check("int_npulses", np_m, 3);

        for (int k = 0; k < N; k++) begin
            e0[k] = 163835;
            e1[k] = 163835;
        end
        es = 131071;
        ew = -98309;
        sweep(1, 0, 2, 0, 0);
        repeat (3) sweep(0, 0, 2, 0, 0);
        sw = 1'b1;
        sweep(0, 1, 2, 0, 0);
        sw = 1'b0;
        check("sat_npulses", np_m, 5);
        check("sat_np_inst", np_s, 5);

        for (int k = 0; k < N; k++) begin
            e0[k] = 2;
            e1[k] = 2;
        end
        sweep(1, 0, 3, 1, 0);
        check("ovr_npulses", np_m, 1);
        sweep(0, 1, 3, 0, 0);
        check("b2b_npulses", np_m, 2);

        for (int k = 0; k < N; k++) begin
            e0[k] = 3;
            e1[k] = 3;
        end
        sweep(0, 1, 3, 0, 1);
        check("rst_valid_after", valid_m, 0);

        for (int k = 0; k < N; k++) begin
            e0[k] = -1024 + k;
            e1[k] = 7;
        end
        sweep(0, 1, 0, 0, 0);
        check("unprimed_npulses", np_m, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
